// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/WB/JUMP/MEM/MEMWB,
// handshakes with instruction/data memory and counts retired instructions.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned ALUOP_W     = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                fetch_ack,
  input  logic                mem_ready,
  output logic                fetch_req,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegDst,
  output logic                ALUSrc,
  output logic                RegWrite,
  output logic                Jump,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemToReg,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                mem_fault,
  output logic [CNT_W-1:0]    instr_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_MOVI = 6'b001010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // Wait counter holds (MEM cycles elapsed - 1), so it only needs 0..MEM_TIMEOUT-1.
  localparam int unsigned        WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    JUMP   = 3'd4,
    MEM    = 3'd5,
    MEMWB  = 3'd6
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [5:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              hi_set;
  logic [5:0]        op_lo;
  logic [1:0]        alu2;

  generate
    if (OPCODE_W > 6) begin : g_hi
      assign hi_set = |opcode[OPCODE_W-1:6];
    end else begin : g_nohi
      assign hi_set = 1'b0;
    end
  endgenerate

  assign op_lo = opcode[5:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      op_q        <= '0;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE) op_q <= op_lo;
      wait_cnt <= (state == MEM) ? wait_cnt + WAIT_W'(1) : '0;
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = FETCH;
    fetch_req  = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegDst     = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    Jump       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    alu2       = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    mem_fault  = 1'b0;

    case (state)
      FETCH: begin
        fetch_req  = 1'b1;
        next_state = FETCH;
        if (fetch_ack) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = DECODE;
        end
      end

      // Routing uses the live opcode; op_q takes the same value on this edge.
      DECODE: begin
        if (hi_set) begin
          illegal_op = 1'b1;
        end else begin
          case (op_lo)
            OP_R, OP_MOVI, OP_ADDI, OP_SUBI: next_state = EXEC;
            OP_J:                            next_state = JUMP;
            OP_LW, OP_SW:                    next_state = MEM;
            default:                         illegal_op = 1'b1;
          endcase
        end
      end

      EXEC, WB: begin
        RegDst = (op_q == OP_R);
        ALUSrc = (op_q != OP_R);
        case (op_q)
          OP_R:    alu2 = 2'b10;
          OP_ADDI: alu2 = 2'b01;
          OP_SUBI: alu2 = 2'b11;
          default: alu2 = 2'b00;
        endcase
        if (state == WB) begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end else begin
          next_state = WB;
        end
      end

      JUMP: begin
        Jump       = 1'b1;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end

      MEM: begin
        ALUSrc   = 1'b1;
        alu2     = 2'b01;
        MemRead  = (op_q == OP_LW);
        MemWrite = (op_q != OP_LW);
        if (mem_ready) begin
          if (op_q == OP_LW) next_state = MEMWB;
          else               instr_done = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          mem_fault = 1'b1;
        end else begin
          next_state = MEM;
        end
      end

      MEMWB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
      end

      default: next_state = FETCH;
    endcase

    ALUOp      = '0;
    ALUOp[1:0] = alu2;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected control
// vectors go through a scoreboard queue and are checked with assertions.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] opcode;
  logic       fetch_ack;
  logic       mem_ready;
  logic       fetch_req, IRWrite, PCWrite, RegDst, ALUSrc, RegWrite, Jump;
  logic       MemRead, MemWrite, MemToReg, instr_done, illegal_op, mem_fault;
  logic [1:0] ALUOp;
  logic [3:0] instr_count;
  logic [14:0] obs;

  int checks   = 0;
  int failures = 0;
  logic [14:0] exp_q[$];
  logic [3:0]  cnt_q[$];

  multicycle_control_unit #(
    .OPCODE_W(8), .ALUOP_W(2), .CNT_W(4), .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .fetch_ack(fetch_ack),
    .mem_ready(mem_ready), .fetch_req(fetch_req), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .Jump(Jump), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_fault(mem_fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {fetch_req, IRWrite, PCWrite, RegDst, ALUSrc, RegWrite, Jump,
                MemRead, MemWrite, MemToReg, ALUOp, instr_done, illegal_op, mem_fault};

  function automatic logic [14:0] v(input logic fr, irw, pcw, rd, as, rw, j,
                                    mr, mw, m2r, input logic [1:0] aop,
                                    input logic dn, il, ft);
    return {fr, irw, pcw, rd, as, rw, j, mr, mw, m2r, aop, dn, il, ft};
  endfunction

  function automatic logic [14:0] f_fetch(input logic ack);
    return v(1, ack, ack, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
  endfunction
  function automatic logic [14:0] f_dec(input logic il);
    return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, il, 0);
  endfunction
  function automatic logic [14:0] f_alu(input logic rd, as, input logic [1:0] aop, input logic wb);
    return v(0, 0, 0, rd, as, wb, 0, 0, 0, 0, aop, wb, 0, 0);
  endfunction
  function automatic logic [14:0] f_jump();
    return v(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0);
  endfunction
  function automatic logic [14:0] f_mem(input logic lw, dn, ft);
    return v(0, 0, 0, 0, 1, 0, 0, lw, !lw, 0, 2'b01, dn, 0, ft);
  endfunction
  function automatic logic [14:0] f_memwb();
    return v(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 1, 0, 0);
  endfunction

  task automatic check_now(input string tag);
    logic [14:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Drive one cycle of inputs, queue the expected controls, compare mid-cycle.
  task automatic step(input logic ack, input logic rdy, input logic [7:0] op,
                      input logic [14:0] e, input string tag);
    fetch_ack = ack;
    mem_ready = rdy;
    opcode    = op;
    exp_q.push_back(e);
    @(negedge clk);
    check_now(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_count(input logic [3:0] e, input string tag);
    logic [3:0] c;
    cnt_q.push_back(e);
    c = cnt_q.pop_front();
    checks++;
    assert (instr_count === c) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, instr_count, c);
    end
  endtask

  initial begin
    reset = 1'b1; opcode = 8'h00; fetch_ack = 1'b0; mem_ready = 1'b0;
    exp_q.push_back(f_fetch(0));
    @(negedge clk);
    check_now("reset_outputs");
    chk_count(4'd0, "reset_count");
    @(posedge clk); #1;
    reset = 1'b0;

    // ADDI with ack held; opcode scrambled after DECODE
    step(1, 0, 8'h3F, f_fetch(1),             "addi_fetch");
    step(1, 0, 8'h08, f_dec(0),               "addi_decode");
    step(1, 1, 8'h23, f_alu(0, 1, 2'b01, 0),  "addi_exec");
    step(1, 1, 8'hFF, f_alu(0, 1, 2'b01, 1),  "addi_wb");
    chk_count(4'd1, "addi_count");

    // R-type, ack delayed 3 cycles
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, f_fetch(0), "r_fetch_wait");
    step(1, 0, 8'h00, f_fetch(1),             "r_fetch_ack");
    step(0, 0, 8'h00, f_dec(0),               "r_decode");
    step(0, 0, 8'h2B, f_alu(1, 0, 2'b10, 0),  "r_exec");
    step(0, 0, 8'h2B, f_alu(1, 0, 2'b10, 1),  "r_wb");
    chk_count(4'd2, "r_count");

    // LW, ready on 2nd MEM cycle
    step(1, 0, 8'h00, f_fetch(1),    "lw_fetch");
    step(1, 0, 8'h23, f_dec(0),      "lw_decode");
    step(1, 0, 8'h2B, f_mem(1, 0, 0), "lw_mem1");
    step(1, 1, 8'h2B, f_mem(1, 0, 0), "lw_mem2");
    step(1, 0, 8'h2B, f_memwb(),     "lw_memwb");
    chk_count(4'd3, "lw_count");

    // SW, immediate ready
    step(1, 0, 8'h00, f_fetch(1),    "sw_fetch");
    step(1, 0, 8'h2B, f_dec(0),      "sw_decode");
    step(1, 1, 8'h23, f_mem(0, 1, 0), "sw_mem");
    chk_count(4'd4, "sw_count");

    // LW timeout
    step(1, 1, 8'h00, f_fetch(1),    "lwto_fetch");
    step(1, 0, 8'h23, f_dec(0),      "lwto_decode");
    for (int i = 0; i < 14; i++) step(1, 0, 8'h00, f_mem(1, 0, 0), "lwto_wait");
    step(1, 0, 8'h00, f_mem(1, 0, 1), "lwto_fault");
    step(0, 0, 8'h00, f_fetch(0),    "lwto_back_fetch");
    chk_count(4'd4, "lwto_count");

    // LW with ready on the 15th MEM cycle
    step(1, 0, 8'h00, f_fetch(1),    "lw15_fetch");
    step(1, 0, 8'h23, f_dec(0),      "lw15_decode");
    for (int i = 0; i < 14; i++) step(1, 0, 8'h00, f_mem(1, 0, 0), "lw15_wait");
    step(1, 1, 8'h00, f_mem(1, 0, 0), "lw15_ready");
    step(1, 0, 8'h00, f_memwb(),     "lw15_memwb");
    chk_count(4'd5, "lw15_count");

    // Illegal opcodes
    step(1, 0, 8'h00, f_fetch(1),    "ill3f_fetch");
    step(1, 0, 8'h3F, f_dec(1),      "ill3f_decode");
    step(1, 0, 8'h00, f_fetch(1),    "ill48_fetch");
    step(1, 0, 8'h48, f_dec(1),      "ill48_decode");
    step(0, 0, 8'h00, f_fetch(0),    "ill_back_fetch");
    chk_count(4'd5, "ill_count");

    // SUBI aborted by reset during WB
    step(1, 0, 8'h00, f_fetch(1),            "subi_fetch");
    step(1, 0, 8'h09, f_dec(0),              "subi_decode");
    step(0, 0, 8'h00, f_alu(0, 1, 2'b11, 0), "subi_exec");
    fetch_ack = 1'b0;
    exp_q.push_back(f_alu(0, 1, 2'b11, 1));
    @(negedge clk);
    check_now("subi_wb");
    #1 reset = 1'b1;
    #1 exp_q.push_back(f_fetch(0));
    check_now("subi_reset_outputs");
    chk_count(4'd0, "subi_reset_count");
    @(posedge clk); #1;
    exp_q.push_back(f_fetch(0));
    check_now("subi_reset_held");
    chk_count(4'd0, "subi_no_increment");
    reset = 1'b0;

    // 16 jumps wrap the 4-bit counter
    for (int n = 1; n <= 16; n++) begin
      step(1, 0, 8'h00, f_fetch(1), "j_fetch");
      step(1, 0, 8'h02, f_dec(0),   "j_decode");
      step(1, 0, 8'h00, f_jump(),   "j_jump");
      if (n == 15) chk_count(4'd15, "j_count_15");
    end
    chk_count(4'd0, "j_count_wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
